iob_gpio_in_capture: RTL



---
 rtl/iob_gpio_in_pkg.sv | 18 +
 rtl/iob_gpio_in_debounce.sv | 56 +++++
 rtl/iob_gpio_in_capture.sv | 123 ++++++++++++
 3 files changed

// File: rtl/iob_gpio_in_pkg.sv
// Shared constants for the GPIO input capture block: register map,
// debounce threshold and default tick-divider width.
package iob_gpio_in_pkg;

  localparam int ADDR_SYNC     = 0;
  localparam int ADDR_DEB      = 1;
  localparam int ADDR_RISE_EN  = 2;
  localparam int ADDR_FALL_EN  = 3;
  localparam int ADDR_EVENT    = 4;
  localparam int ADDR_IRQ_MASK = 5;
  localparam int ADDR_DEB_DIV  = 6;

  // Counter value meaning "four equal consecutive samples".
  localparam int STABLE_CNT    = 3;

  localparam int DEFAULT_DIV_W = 16;

endpackage

// File: rtl/iob_gpio_in_debounce.sv
// One input pin: 2-flop synchroniser followed by a tick-sampled debouncer
// with a 2-bit saturating stability counter.
module iob_gpio_in_debounce
  import iob_gpio_in_pkg::*;
(
  input  logic clk,
  input  logic arst_n,
  input  logic pin,
  input  logic tick,
  input  logic primed,
  output logic sync_val,
  output logic deb_val
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic       deb_r;
  logic [1:0] cnt_q;
  logic [1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (sync_q == prev_q) begin
      cnt_next = (cnt_q == 2'(STABLE_CNT)) ? cnt_q : cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      deb_r  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      if (tick) begin
        prev_q <= sync_q;
        if (!primed) begin
          // First tick after reset adopts the pin level without filtering.
          deb_r <= sync_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_next;
          if (cnt_next == 2'(STABLE_CNT)) deb_r <= sync_q;
        end
      end
    end
  end

  assign sync_val = sync_q;
  assign deb_val  = deb_r;

endmodule

// File: rtl/iob_gpio_in_capture.sv
// GPIO input capture: synchronised and debounced pins, edge detection into a
// sticky W1C event register, and a maskable level interrupt on the native bus.
module iob_gpio_in_capture
  import iob_gpio_in_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DIV_W  = DEFAULT_DIV_W
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                iob_valid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_ready,
  input  logic [GPIO_W-1:0]   gpio_input,
  output logic                gpio_irq
);

  // Bus handshake: every cycle with iob_valid high is one request; it is
  // acked by iob_ready exactly one cycle later, with iob_rdata valid then and
  // held until the next request. Non-zero iob_wstrb marks a write, whose
  // register effect is visible from the ack cycle onwards.

  logic [GPIO_W-1:0] sync_vec, deb_vec, deb_q;
  logic [GPIO_W-1:0] rise_en_q, fall_en_q, event_q, irq_mask_q;
  logic [GPIO_W-1:0] rise, fall, w1c, event_next;
  logic [GPIO_W-1:0] wdata_g, wmask_g;
  logic [DIV_W-1:0]  deb_div_q, div_cnt_q;
  logic [DATA_W-1:0] wmask, rd_val, rdata_q;
  logic              tick, primed_q, edge_en_q, ready_q, irq_q;
  logic              is_write;
  logic              wr_rise, wr_fall, wr_event, wr_mask, wr_div;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < DATA_W/8; b++) wmask[b*8 +: 8] = {8{iob_wstrb[b]}};
  end

  assign wdata_g  = iob_wdata[GPIO_W-1:0];
  assign wmask_g  = wmask[GPIO_W-1:0];
  assign is_write = iob_valid && (|iob_wstrb);
  assign wr_rise  = is_write && (iob_addr == ADDR_W'(ADDR_RISE_EN));
  assign wr_fall  = is_write && (iob_addr == ADDR_W'(ADDR_FALL_EN));
  assign wr_event = is_write && (iob_addr == ADDR_W'(ADDR_EVENT));
  assign wr_mask  = is_write && (iob_addr == ADDR_W'(ADDR_IRQ_MASK));
  assign wr_div   = is_write && (iob_addr == ADDR_W'(ADDR_DEB_DIV));

  assign tick = (div_cnt_q == deb_div_q);

  for (genvar i = 0; i < GPIO_W; i++) begin : g_bit
    iob_gpio_in_debounce u_debounce (
      .clk      (clk),
      .arst_n   (arst_n),
      .pin      (gpio_input[i]),
      .tick     (tick),
      .primed   (primed_q),
      .sync_val (sync_vec[i]),
      .deb_val  (deb_vec[i])
    );
  end

  // edge_en_q lags primed_q so the priming load of DEB never looks like an edge.
  assign rise       = deb_vec & ~deb_q & rise_en_q & {GPIO_W{edge_en_q}};
  assign fall       = ~deb_vec & deb_q & fall_en_q & {GPIO_W{edge_en_q}};
  assign w1c        = wr_event ? (wdata_g & wmask_g) : '0;
  assign event_next = (event_q & ~w1c) | rise | fall;

  always_comb begin
    rd_val = '0;
    case (iob_addr)
      ADDR_W'(ADDR_SYNC):     rd_val[GPIO_W-1:0] = sync_vec;
      ADDR_W'(ADDR_DEB):      rd_val[GPIO_W-1:0] = deb_vec;
      ADDR_W'(ADDR_RISE_EN):  rd_val[GPIO_W-1:0] = rise_en_q;
      ADDR_W'(ADDR_FALL_EN):  rd_val[GPIO_W-1:0] = fall_en_q;
      ADDR_W'(ADDR_EVENT):    rd_val[GPIO_W-1:0] = event_q;
      ADDR_W'(ADDR_IRQ_MASK): rd_val[GPIO_W-1:0] = irq_mask_q;
      ADDR_W'(ADDR_DEB_DIV):  rd_val[DIV_W-1:0]  = deb_div_q;
      default:                rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      div_cnt_q  <= '0;
      primed_q   <= 1'b0;
      edge_en_q  <= 1'b0;
      deb_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      event_q    <= '0;
      irq_mask_q <= '0;
      deb_div_q  <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_div || tick) div_cnt_q <= '0;
      else                div_cnt_q <= div_cnt_q + DIV_W'(1);
      if (tick) primed_q <= 1'b1;
      edge_en_q <= primed_q;
      deb_q     <= deb_vec;
      if (wr_rise) rise_en_q  <= (rise_en_q & ~wmask_g) | (wdata_g & wmask_g);
      if (wr_fall) fall_en_q  <= (fall_en_q & ~wmask_g) | (wdata_g & wmask_g);
      if (wr_mask) irq_mask_q <= (irq_mask_q & ~wmask_g) | (wdata_g & wmask_g);
      if (wr_div) begin
        deb_div_q <= (deb_div_q & ~wmask[DIV_W-1:0]) | (iob_wdata[DIV_W-1:0] & wmask[DIV_W-1:0]);
      end
      event_q <= event_next;
      irq_q   <= |(event_next & irq_mask_q);
      ready_q <= iob_valid;
      if (iob_valid) rdata_q <= rd_val;
    end
  end

  assign iob_rdata = rdata_q;
  assign iob_ready = ready_q;
  assign gpio_irq  = irq_q;

endmodule
